uart_receiver: RTL and testbench

//  8N1 UART receive front end. Oversamples the asynchronous UART_RX pin, recovers each byte
//  LSB-first and holds it in a one-entry buffer. It sits directly upstream of the peripheral

---
 rtl/uart_receiver.sv | 142 ++++++++++++++
 tb/tb_uart_receiver.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling FSM and a one-entry
// output buffer with framing-error pulse and sticky overrun flag.
module uart_receiver #(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       UART_RX,
  input  logic       rx_ack,
  input  logic       overrun_clr,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    WAIT_HI = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic             sync1_q, rxs_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic             deliver_c;

  // State register, synchroniser and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      sync1_q     <= 1'b1;
      rxs_q       <= 1'b1;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= UART_RX;
      rxs_q       <= sync1_q;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  // Next-state, datapath and output-buffer logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shreg_d     = shreg_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = overrun_q;
    deliver_c   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!rxs_q) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rxs_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          shreg_d   = {rxs_q, shreg_q[7:1]};
          cnt_d     = '0;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rxs_q) begin
            deliver_c = 1'b1;
            state_d   = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAIT_HI;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_HI: begin
        if (rxs_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A new overrun outranks a same-cycle clear; delivery outranks ack
    if (overrun_clr) overrun_d = 1'b0;
    if (deliver_c) begin
      rx_data_d  = shreg_q;
      rx_valid_d = 1'b1;
      if (rx_valid_q && !rx_ack) overrun_d = 1'b1;
    end else if (rx_ack) begin
      rx_valid_d = 1'b0;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver at CLKS_PER_BIT=16: stimulus pushes expected
// bytes, a negedge monitor pops and compares on every delivery.
module tb_uart_receiver;

  localparam int unsigned CPB  = 16;
  localparam int unsigned HALF = CPB / 2;
  localparam int          LAT  = 2 + HALF + 9 * CPB + 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       UART_RX;
  logic       rx_ack;
  logic       overrun_clr;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;

  typedef struct {
    logic [7:0] data;
    logic       ovr;
    int         exp_cyc;
  } exp_t;

  exp_t       sb[$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         fe_pulses = 0;
  int         fe_cycles = 0;
  logic       mon_pv = 1'b0;
  logic [7:0] mon_pd = 8'h00;
  logic       mon_pfe = 1'b0;
  exp_t       mon_e;

  uart_receiver #(.CLKS_PER_BIT(CPB), .HALF_BIT(HALF)) dut (
    .clk(clk), .reset(reset), .UART_RX(UART_RX), .rx_ack(rx_ack),
    .overrun_clr(overrun_clr), .rx_data(rx_data), .rx_valid(rx_valid),
    .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One full 10-bit frame; pushes the expectation if the stop bit is good.
  // The line is left at the stop-bit level afterwards.
  task automatic send(input logic [7:0] b, input logic stop, input logic ovr,
                      input logic ack_dlv, input logic chk_lat);
    logic [9:0] fr;
    int         k;
    fr = {stop, b, 1'b0};
    k  = cyc;
    if (stop) sb.push_back('{data: b, ovr: ovr, exp_cyc: chk_lat ? k + LAT : -1});
    for (int i = 0; i < 10 * int'(CPB); i++) begin
      UART_RX = fr[i / int'(CPB)];
      rx_ack  = ack_dlv && (i == LAT - 1);
      @(posedge clk);
      #1;
    end
    rx_ack = 1'b0;
  endtask

  task automatic ack();
    rx_ack = 1'b1;
    idle(1);
    rx_ack = 1'b0;
  endtask

  // Monitor: a delivery is rx_valid rising or new data while valid
  initial begin
    forever begin
      @(negedge clk);
      if (rx_valid && (!mon_pv || rx_data != mon_pd)) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_delivery: got data 0x%0h, no byte expected", rx_data);
        end else begin
          mon_e = sb.pop_front();
          check("rx_data", int'(rx_data), int'(mon_e.data));
          check("overrun_at_delivery", int'(overrun), int'(mon_e.ovr));
          if (mon_e.exp_cyc >= 0) check("latency_cycle", cyc, mon_e.exp_cyc);
        end
      end
      if (frame_err) begin
        fe_cycles++;
        if (!mon_pfe) fe_pulses++;
      end
      mon_pv  = rx_valid;
      mon_pd  = rx_data;
      mon_pfe = frame_err;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] fr;
    UART_RX     = 1'b1;
    reset       = 1'b1;
    rx_ack      = 1'b0;
    overrun_clr = 1'b0;
    idle(3);
    check("reset_rx_data", int'(rx_data), 0);
    check("reset_rx_valid", int'(rx_valid), 0);
    check("reset_frame_err", int'(frame_err), 0);
    check("reset_overrun", int'(overrun), 0);
    reset = 1'b0;
    idle(5);

    // Basic frame with exact latency
    send(8'hA7, 1'b1, 1'b0, 1'b0, 1'b1);
    UART_RX = 1'b1;
    idle(2);
    check("t1_rx_valid", int'(rx_valid), 1);
    check("t1_no_frame_err", fe_pulses, 0);
    ack();
    check("t1_ack_clears_valid", int'(rx_valid), 0);
    idle(CPB);

    // Short glitch is rejected
    UART_RX = 1'b0;
    idle(4);
    UART_RX = 1'b1;
    idle(3 * CPB);
    check("t2_glitch_no_valid", int'(rx_valid), 0);
    check("t2_glitch_no_frame_err", fe_pulses, 0);
    send(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
    UART_RX = 1'b1;
    idle(2);
    check("t2_rx_valid", int'(rx_valid), 1);
    ack();
    idle(CPB);

    // Framing error, then break held low
    send(8'h96, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(100);
    check("t3_frame_err_pulses", fe_pulses, 1);
    check("t3_frame_err_width", fe_cycles, 1);
    check("t3_no_valid", int'(rx_valid), 0);
    UART_RX = 1'b1;
    idle(2 * CPB);
    check("t3_no_retrigger", fe_pulses, 1);
    send(8'h96, 1'b1, 1'b0, 1'b0, 1'b0);
    UART_RX = 1'b1;
    idle(2);
    check("t3_rx_valid", int'(rx_valid), 1);
    ack();
    idle(CPB);

    // Overrun and its clear
    send(8'h96, 1'b1, 1'b0, 1'b0, 1'b0);
    UART_RX = 1'b1;
    idle(CPB);
    send(8'hFF, 1'b1, 1'b1, 1'b0, 1'b0);
    UART_RX = 1'b1;
    idle(2);
    check("t4_overrun", int'(overrun), 1);
    check("t4_rx_valid", int'(rx_valid), 1);
    check("t4_rx_data", int'(rx_data), 8'hFF);
    overrun_clr = 1'b1;
    idle(1);
    overrun_clr = 1'b0;
    check("t4_overrun_cleared", int'(overrun), 0);
    check("t4_valid_kept", int'(rx_valid), 1);
    ack();
    check("t4_ack_clears_valid", int'(rx_valid), 0);
    idle(CPB);

    // Ack coinciding with a delivery
    send(8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
    UART_RX = 1'b1;
    idle(CPB);
    send(8'h22, 1'b1, 1'b0, 1'b1, 1'b0);
    UART_RX = 1'b1;
    idle(2);
    check("t5_rx_valid", int'(rx_valid), 1);
    check("t5_rx_data", int'(rx_data), 8'h22);
    check("t5_no_overrun", int'(overrun), 0);
    idle(CPB);

    // Reset in the middle of data bit 4
    fr = {1'b1, 8'h5A, 1'b0};
    for (int i = 0; i < 5 * int'(CPB) + int'(HALF); i++) begin
      UART_RX = fr[i / int'(CPB)];
      idle(1);
    end
    reset = 1'b1;
    idle(1);
    reset   = 1'b0;
    UART_RX = 1'b1;
    check("t6_reset_rx_data", int'(rx_data), 0);
    check("t6_reset_rx_valid", int'(rx_valid), 0);
    check("t6_reset_frame_err", int'(frame_err), 0);
    check("t6_reset_overrun", int'(overrun), 0);
    idle(3 * CPB);
    check("t6_aborted_no_valid", int'(rx_valid), 0);
    send(8'h5A, 1'b1, 1'b0, 1'b0, 1'b1);
    UART_RX = 1'b1;
    idle(2);
    check("t6_rx_valid", int'(rx_valid), 1);
    idle(CPB);

    check("scoreboard_drained", sb.size(), 0);
    check("total_frame_err_pulses", fe_pulses, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
